// File: rtl/button_press_decoder.sv
// Turns a debounced button level into one-cycle press, short, long, repeat and
// release events, plus a registered "held" level for downstream control FSMs.
module button_press_decoder #(
    parameter int LONG_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clean,
    output logic press_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic release_pulse,
    output logic held
);

    typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q;
    logic             press_q, press_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;
    logic             rel_q, rel_d;
    logic             held_q, held_d;
    logic             rise;

    assign rise = clean & ~clean_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        rel_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    cnt_d   = '0;
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                // Release is tested first so it wins over a threshold hit.
                if (!clean) begin
                    short_d = 1'b1;
                    rel_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (!clean) begin
                    rel_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == REP_LAST) begin
                    rep_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        held_d = (state_d != IDLE);
    end

    // clean_q resets high so a button held through reset is not seen as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            clean_q <= 1'b1;
            press_q <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            rel_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean;
            press_q <= press_d;
            short_q <= short_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            rel_q   <= rel_d;
            held_q  <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign short_press   = short_q;
    assign long_press    = long_q;
    assign repeat_pulse  = rep_q;
    assign release_pulse = rel_q;
    assign held          = held_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Bench for button_press_decoder: an edge-indexed hold-time model checked every
// cycle, plus directed scenarios with hand-computed event edges.
module tb_button_press_decoder;

    localparam int LONG = 8;
    localparam int REP  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clean = 1'b1;
    logic press_pulse, short_press, long_press, repeat_pulse, release_pulse, held;

    button_press_decoder #(.LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .clean(clean),
        .press_pulse(press_pulse), .short_press(short_press), .long_press(long_press),
        .repeat_pulse(repeat_pulse), .release_pulse(release_pulse), .held(held)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int misc = 0;
    int ecnt = 0;

    // model state: an active press is just the edge index where it began
    bit m_active = 1'b0;
    bit m_prev = 1'b1;
    int m_k = 0;
    int m_long_e = -1;
    int m_press_e = -1;

    // observed DUT events
    int n_press, n_short, n_long, n_rep, n_rel, n_held;
    int p_first, p_e, s_first, s_e, l_e, r_e, rep_first, rep_e;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            misc++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    task automatic clr();
        n_press = 0; n_short = 0; n_long = 0; n_rep = 0; n_rel = 0; n_held = 0;
        p_first = -1; p_e = -1; s_first = -1; s_e = -1; l_e = -1; r_e = -1;
        rep_first = -1; rep_e = -1; m_long_e = -1; m_press_e = -1;
    endtask

    // return at the falling edge just after edge e-1, so a new clean is sampled at edge e
    task automatic at_edge(input int e);
        while (ecnt < e - 1) @(negedge clk);
    endtask

    always @(posedge clk) begin
        logic [5:0] exp_v, act_v;
        int d;
        ecnt++;
        exp_v = '0; // {press, short, long, repeat, release, held}
        if (!rst_n) begin
            m_active = 1'b0;
            m_prev   = 1'b1;
        end else begin
            if (m_active) begin
                d = ecnt - m_k;
                if (!clean) begin
                    exp_v[1] = 1'b1;
                    exp_v[4] = (d <= LONG);
                    m_active = 1'b0;
                end else if (d == LONG) begin
                    exp_v[3] = 1'b1;
                    m_long_e = ecnt;
                end else if (d > LONG && (d - LONG) % REP == 0) begin
                    exp_v[2] = 1'b1;
                end
            end else if (clean && !m_prev) begin
                exp_v[5]  = 1'b1;
                m_k       = ecnt;
                m_active  = 1'b1;
                m_press_e = ecnt;
            end
            exp_v[0] = m_active;
            m_prev   = clean;
        end
        #1;
        act_v = {press_pulse, short_press, long_press, repeat_pulse, release_pulse, held};
        exp_v = {exp_v[5], exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]};
        chk("cycle_outputs", int'(act_v), int'(exp_v));
        if (rst_n) begin
            if (press_pulse)   begin n_press++; p_e = ecnt; if (p_first < 0) p_first = ecnt; end
            if (short_press)   begin n_short++; s_e = ecnt; if (s_first < 0) s_first = ecnt; end
            if (long_press)    begin n_long++; l_e = ecnt; end
            if (repeat_pulse)  begin n_rep++; rep_e = ecnt; if (rep_first < 0) rep_first = ecnt; end
            if (release_pulse) begin n_rel++; r_e = ecnt; end
            if (held)          n_held++;
        end
    end

    initial begin
        int base;
        clr();
        // 1: button held through reset
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({press_pulse, short_press, long_press, repeat_pulse, release_pulse, held}), 0);
        rst_n = 1'b1;
        clr();
        repeat (20) @(negedge clk);
        clean = 1'b0;
        repeat (5) @(negedge clk);
        chk("s1_pulses", n_press + n_short + n_long + n_rep + n_rel, 0);
        chk("s1_held", n_held, 0);

        // 2: short press
        clr(); base = ecnt;
        at_edge(base + 10); clean = 1'b1;
        at_edge(base + 14); clean = 1'b0;
        at_edge(base + 20);
        chk("s2_press_edge", p_e - base, 10);
        chk("s2_model_press_edge", m_press_e - base, 10);
        chk("s2_short_edge", s_e - base, 14);
        chk("s2_release_edge", r_e - base, 14);
        chk("s2_held_cycles", n_held, 4);
        chk("s2_long_count", n_long, 0);

        // 3: long hold with repeats; release wins over the repeat due at 30
        clr(); base = ecnt;
        at_edge(base + 10); clean = 1'b1;
        at_edge(base + 30); clean = 1'b0;
        at_edge(base + 34);
        chk("s3_long_edge", l_e - base, 18);
        chk("s3_model_long_edge", m_long_e - base, 18);
        chk("s3_first_repeat", rep_first - base, 22);
        chk("s3_last_repeat", rep_e - base, 26);
        chk("s3_repeat_count", n_rep, 2);
        chk("s3_release_edge", r_e - base, 30);
        chk("s3_short_count", n_short, 0);

        // 4: release on the long-threshold edge
        clr(); base = ecnt;
        at_edge(base + 10); clean = 1'b1;
        at_edge(base + 18); clean = 1'b0;
        at_edge(base + 22);
        chk("s4_short_edge", s_e - base, 18);
        chk("s4_release_edge", r_e - base, 18);
        chk("s4_long_count", n_long, 0);

        // 5: reset while in REPEAT, button still down afterwards
        clr(); base = ecnt;
        at_edge(base + 10); clean = 1'b1;
        at_edge(base + 25);
        chk("s5_held_before_reset", int'(held), 1);
        rst_n = 1'b0;
        #1;
        chk("s5_async_reset", int'({press_pulse, short_press, long_press, repeat_pulse, release_pulse, held}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clr();
        at_edge(base + 35); clean = 1'b0;
        at_edge(base + 40); clean = 1'b1;
        at_edge(base + 44); clean = 1'b0;
        at_edge(base + 48);
        chk("s5_press_count", n_press, 1);
        chk("s5_press_edge", p_e - base, 40);
        chk("s5_release_count", n_rel, 1);

        // 6: back-to-back presses
        clr(); base = ecnt;
        at_edge(base + 10); clean = 1'b1;
        at_edge(base + 14); clean = 1'b0;
        at_edge(base + 15); clean = 1'b1;
        at_edge(base + 17); clean = 1'b0;
        at_edge(base + 21);
        chk("s6_first_short", s_first - base, 14);
        chk("s6_second_press", p_e - base, 15);
        chk("s6_press_count", n_press, 2);
        chk("s6_release_edge", r_e - base, 17);
        chk("s6_held_cycles", n_held, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
